// File: rtl/ysyx_lsu_pkg.sv
// Shared types and constants for the load/store stage.
// Misalignment helper is used only when YSYX_LSU_MISALIGN_EN is defined.
package ysyx_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
        logic        we;
        logic        ebreak;
    } req_t;

    // Undefined funct3 encodings behave as word accesses.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic we,
                                           input logic [1:0] off);
        logic mis;
        if (we) begin
            case (f3)
                F3_SB:   mis = 1'b0;
                F3_SH:   mis = off[0];
                default: mis = (off != 2'b00);
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: mis = 1'b0;
                F3_LH, F3_LHU: mis = off[0];
                default:       mis = (off != 2'b00);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_lsu_if.sv
// Simple memory request/response bus between the LSU (master) and memory (slave).
// Request holds until mem_req_ready; one response per accepted request.
interface ysyx_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
    );
endinterface

// File: rtl/ysyx_lsu_align.sv
// Store strobe/data lane placement and load lane extraction with extension.
// Purely combinational, zero latency, no flow control.
module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [15:0] lane;

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
        load_o  = rdata_i;
        // Shifting in zeros means a halfword at offset 3 does not wrap.
        lane    = 16'(rdata_i >> {off_i, 3'b000});

        if (we_i) begin
            case (funct3_i)
                F3_SB: begin
                    wstrb_o = 4'b0001 << off_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_SH: begin
                    wstrb_o = 4'b0011 << off_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: wstrb_o = 4'b1111;
            endcase
        end

        case (funct3_i)
            F3_LB:   load_o = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   load_o = {{16{lane[15]}}, lane};
            F3_LBU:  load_o = {24'h0, lane[7:0]};
            F3_LHU:  load_o = {16'h0, lane};
            default: load_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu.sv
// Blocking single-entry load/store stage; optional misalignment trap via YSYX_LSU_MISALIGN_EN.
// Non-memory result 1 cycle after accept, memory >= 3; holds valid_o until next_ready.
module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            ren,
    input  logic            wen,
    input  logic [2:0]      funct3,
    input  logic            ebreak,
    input  logic [XLEN-1:0] alu_res,
    input  logic            prev_valid,
    output logic            ready_o,
    output logic            valid_o,
    input  logic            next_ready,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            ebreak_o,
    output logic            fault_o,
    output logic [3:0]      cause_o,
    ysyx_lsu_if.master      mem
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [3:0]  cause_q, cause_d;

    logic        misalign;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

`ifdef YSYX_LSU_MISALIGN_EN
    assign misalign = (ren | wen) & is_misaligned(funct3, wen, addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    ysyx_lsu_align u_align (
        .funct3_i (req_q.funct3),
        .we_i     (req_q.we),
        .off_i    (req_q.addr[1:0]),
        .wdata_i  (req_q.wdata),
        .rdata_i  (mem.mem_resp_data),
        .wstrb_o  (al_wstrb),
        .wdata_o  (al_wdata),
        .load_o   (al_load)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        cause_d = cause_q;

        case (state_q)
            S_IDLE: begin
                if (prev_valid) begin
                    req_d.pc     = pc;
                    req_d.inst   = inst;
                    req_d.addr   = addr;
                    req_d.wdata  = wdata;
                    req_d.funct3 = funct3;
                    req_d.we     = wen;
                    req_d.ebreak = ebreak;
                    rdata_d      = '0;
                    fault_d      = 1'b0;
                    cause_d      = '0;
                    if (misalign) begin
                        fault_d = 1'b1;
                        cause_d = wen ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
                        state_d = S_DONE;
                    end else if (!(ren | wen)) begin
                        rdata_d = alu_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem.mem_resp_valid) begin
                    state_d = S_DONE;
                    if (mem.mem_resp_err) begin
                        fault_d = 1'b1;
                        cause_d = req_q.we ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                        rdata_d = '0;
                    end else begin
                        rdata_d = req_q.we ? 32'h0 : al_load;
                    end
                end
            end
            S_DONE: begin
                if (next_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    // Every output decodes flops only; no input reaches an output combinationally.
    assign ready_o           = (state_q == S_IDLE);
    assign valid_o           = (state_q == S_DONE);
    assign pc_o              = req_q.pc;
    assign inst_o            = req_q.inst;
    assign ebreak_o          = req_q.ebreak;
    assign rdata_o           = rdata_q;
    assign fault_o           = fault_q;
    assign cause_o           = cause_q;
    assign mem.mem_req_valid = (state_q == S_REQ);
    assign mem.mem_we        = req_q.we;
    assign mem.mem_addr      = {req_q.addr[31:2], 2'b00};
    assign mem.mem_wdata     = al_wdata;
    assign mem.mem_wstrb     = al_wstrb;

endmodule

// File: doc/ysyx_lsu.md
# ysyx_lsu

Load/store stage between the execute unit and the write-back unit. It accepts one instruction at a time from the execute stage over a valid/ready handshake, performs at most one memory access on a simple request/response bus, and presents the result to write-back. Write-back consumes `pc_o`, `inst_o`, `rdata_o` and `ebreak_o`. Blocking, single-entry: at most one instruction in flight.

## Interface
Parameters:
- `XLEN`, 32: data and address width. Only 32 is supported.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset; synchronous, active-high.
- `pc`, `inst`  in  32 each: instruction identity from the execute stage.
- `addr`  in  32: effective address, from the ALU result.
- `wdata`  in  32: store source (rs2).
- `ren`, `wen`  in  1 each: load or store. Both high is illegal and is treated as a store.
- `funct3`  in  3: access size and sign.
- `ebreak`  in  1: passed through to write-back.
- `alu_res`  in  32: forwarded as `rdata_o` for non-memory instructions.
- `prev_valid`  in  1; `ready_o`  out  1: upstream handshake.
- `valid_o`  out  1; `next_ready`  in  1: downstream handshake.
- `pc_o`, `inst_o`, `rdata_o`  out  32 each; `ebreak_o`  out  1: results to write-back.
- `fault_o`  out  1; `cause_o`  out  4: exception report, valid together with `valid_o`.
- `mem_req_valid`  out  1; `mem_req_ready`  in  1: bus request handshake.
- `mem_we`  out  1; `mem_addr`  out  32 (word-aligned); `mem_wdata`  out  32; `mem_wstrb`  out  4: bus request fields.
- `mem_resp_valid`  in  1; `mem_resp_data`  in  32; `mem_resp_err`  in  1: bus response.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE:** `ready_o`=1. On `prev_valid & ready_o`, capture all inputs and drop `ready_o`.
  - If neither `ren` nor `wen`: go to DONE with `rdata_o`=`alu_res`.
  - Otherwise go to REQ.
- **REQ:** `mem_req_valid`=1. All request fields stay stable until `mem_req_ready`, then go to WAIT.
- **WAIT:** on `mem_resp_valid`, latch the response and go to DONE.
  - Load result is extracted from lane `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the whole word.
  - Stores return `rdata_o`=0.
- **DONE:** `valid_o`=1 with all outputs stable. On `next_ready`, go to IDLE, set `ready_o`=1 and clear `valid_o`.
- **Store lanes:**
  - SB: `mem_wstrb` = 4'b0001<<`addr[1:0]`, data byte replicated to all 4 lanes.
  - SH: `mem_wstrb` = 4'b0011<<`addr[1:0]`, truncated to 4 bits; data halfword replicated.
  - SW: `mem_wstrb` = 4'b1111.
- **Bus fields:** `mem_addr` = {`addr[31:2]`, 2'b00}. `mem_we`=`wen`.
- **Bus error:** `mem_resp_err`=1 sets `fault_o`=1 with `cause_o` = 5 for a load or 7 for a store, and `rdata_o`=0.
- Undefined `funct3` is treated as LW/SW.

## Timing
- **Reset values:** `ready_o`=1. `valid_o`, `mem_req_valid`, `fault_o`, `ebreak_o` = 0. `cause_o`=0. Data outputs = 0. State = IDLE.
- **Latency:** acceptance in cycle T.
  - Non-memory instruction: `valid_o` rises at T+1.
  - Memory instruction: `mem_req_valid` rises at T+1. With zero-wait ready and response at T+2, `valid_o` rises at T+3.
- `valid_o` is never asserted in the same cycle as `ready_o`, so there is no back-to-back acceptance. Maximum throughput is one instruction per 2 cycles (non-memory).
- `mem_resp_valid` outside WAIT is ignored.
- `next_ready` held high while waiting does not shorten DONE: DONE lasts at least one cycle.
- **Reset mid-operation:** returns to IDLE immediately and drops `mem_req_valid`. The bus is reset by the same `rst`, so no stale response can arrive.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `YSYX_LSU_MISALIGN_EN`.
- **Defined:**
  - LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, does not reach the bus.
  - Acceptance goes straight to DONE with `fault_o`=1.
  - `cause_o` = 4 for a load or 6 for a store.
- **Undefined:** no check. The access is issued with the shifted and truncated strobe described under Operation, and the load extracts from the shifted lane with no wrap. `fault_o` is only ever raised by `mem_resp_err`.

## Structure
- **Package `ysyx_lsu_pkg`:**
  - state enum (IDLE/REQ/WAIT/DONE);
  - `funct3` constants LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2;
  - cause codes 4/5/6/7.
- **Sub-module `ysyx_lsu_align`:** combinational; computes the store strobe and data, and performs load lane extraction and extension.
- The FSM, capture registers and bus interface live in `ysyx_lsu`.

## Test plan
- Non-memory: `alu_res`=0x1234, `next_ready`=1 → `valid_o` at T+1 with `rdata_o`=0x1234; `ready_o` is back at 1 at T+2.
- LB at `addr`=0x8000_0003 with `mem_resp_data`=0x80FF_FFFF → `mem_addr`=0x8000_0000, `rdata_o`=0xFFFF_FF80. LBU on the same access → 0x0000_0080.
- SH at `addr`=0x8000_0002 with `wdata`=0xAAAA_BEEF → `mem_wstrb`=4'b1100, `mem_wdata`=0xBEEF_BEEF. `mem_req_ready` held low for 3 cycles → all request fields stay stable.
- LW with `mem_resp_err`=1 → `fault_o`=1, `cause_o`=5, `rdata_o`=0.
- With `YSYX_LSU_MISALIGN_EN` defined, SW at 0x8000_0001 → no `mem_req_valid`, `valid_o` at T+1 with `cause_o`=6.
- `next_ready`=0 for 4 cycles in DONE → `valid_o` and all outputs hold. `rst` asserted in WAIT → next cycle IDLE with `ready_o`=1 and `valid_o`=0.
